// File: rtl/mp_cache_line_adapter_pkg.sv
// -----------------------------------------------------------------------------
// mp_cache_types
// Shared widths, state encoding and small helpers for the cache line adapter.
// The cache controller and the data array also use line_t, so the line width
// is defined once here.
// -----------------------------------------------------------------------------
package mp_cache_types;

  localparam int LINE_WIDTH     = 256;
  localparam int BEAT_WIDTH     = 64;
  localparam int ADDR_WIDTH     = 32;
  localparam int BEATS          = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFSET_BITS    = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH      = $clog2(BEATS);
  localparam int BEAT_SHIFT     = $clog2(BEAT_WIDTH);
  localparam int LINE_IDX_WIDTH = $clog2(LINE_WIDTH);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BEATS - 1);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_DATA  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } adapter_state_t;

  // Bit offset of beat 'idx' inside a line; beat 0 is the least significant.
  function automatic logic [LINE_IDX_WIDTH-1:0] beat_base(input logic [CNT_WIDTH-1:0] idx);
    beat_base = {idx, {BEAT_SHIFT{1'b0}}};
  endfunction

  // Clear the line-offset bits so the burst always starts on a line boundary.
  function automatic addr_t line_align(input addr_t addr);
    line_align = {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mp_cache_line_adapter.sv
// -----------------------------------------------------------------------------
// mp_cache_line_adapter
// Bridges the cache's 256-bit line port (dfp_*) and the 64-bit, 4-beat burst
// memory port (bmem_*). Fills assemble four read beats into one line;
// writebacks split a latched line into four write beats. One transaction at
// a time.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   dfp_addr      : line address from the cache (offset bits ignored)
//   dfp_read      : fill request, held until dfp_resp
//   dfp_write     : writeback request, held until dfp_resp (wins over read)
//   dfp_wdata     : writeback line, captured when the request is accepted
//   dfp_rdata     : assembled fill line, stable from dfp_resp to next request
//   dfp_resp      : one-cycle completion pulse
//   bmem_addr     : line-aligned burst address
//   bmem_read     : burst read request
//   bmem_write    : write beat valid
//   bmem_wdata    : current write beat (beat 0 = line bits [63:0])
//   bmem_ready    : memory accepts the read request / write beat this cycle
//   bmem_raddr    : tag of a returning beat (unused, one transaction only)
//   bmem_rdata    : read beat data
//   bmem_rvalid   : read beat valid
//
// All outputs come straight from flops: the control outputs are precomputed
// from the next state so their timing matches a state-decoded Moore output.
// -----------------------------------------------------------------------------
module mp_cache_line_adapter
  import mp_cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  adapter_state_t        state_r;
  adapter_state_t        state_next_s;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [CNT_WIDTH-1:0]  cnt_next_s;
  addr_t                 addr_r;
  addr_t                 addr_next_s;
  line_t                 line_r;
  line_t                 line_next_s;

  logic                  bmem_read_r;
  logic                  bmem_read_next_s;
  logic                  bmem_write_r;
  logic                  bmem_write_next_s;
  beat_t                 bmem_wdata_r;
  beat_t                 bmem_wdata_next_s;
  logic                  dfp_resp_r;
  logic                  dfp_resp_next_s;

  // Only one burst is ever in flight, so the returning tag and the line
  // offset bits carry no information.
  logic                  unused_bits_s;
  assign unused_bits_s = ^{bmem_raddr, dfp_addr[OFFSET_BITS-1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      addr_r       <= '0;
      line_r       <= '0;
      bmem_read_r  <= 1'b0;
      bmem_write_r <= 1'b0;
      bmem_wdata_r <= '0;
      dfp_resp_r   <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      addr_r       <= addr_next_s;
      line_r       <= line_next_s;
      bmem_read_r  <= bmem_read_next_s;
      bmem_write_r <= bmem_write_next_s;
      bmem_wdata_r <= bmem_wdata_next_s;
      dfp_resp_r   <= dfp_resp_next_s;
    end
  end

  // Next-state, beat counter, address latch and line buffer update.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    addr_next_s  = addr_r;
    line_next_s  = line_r;

    case (state_r)
      IDLE: begin
        // Write takes priority when both requests are raised together.
        if (dfp_write) begin
          addr_next_s  = line_align(dfp_addr);
          line_next_s  = dfp_wdata;
          cnt_next_s   = '0;
          state_next_s = WR_BURST;
        end else if (dfp_read) begin
          addr_next_s  = line_align(dfp_addr);
          cnt_next_s   = '0;
          state_next_s = RD_REQ;
        end else begin
          state_next_s = IDLE;
        end
      end

      RD_REQ: begin
        if (bmem_ready) begin
          state_next_s = RD_DATA;
        end else begin
          state_next_s = RD_REQ;
        end
      end

      RD_DATA: begin
        // Beats may arrive with gaps; only valid cycles advance the counter.
        if (bmem_rvalid) begin
          line_next_s[beat_base(cnt_r) +: BEAT_WIDTH] = bmem_rdata;
          cnt_next_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_next_s = RESP;
          end else begin
            state_next_s = RD_DATA;
          end
        end else begin
          state_next_s = RD_DATA;
        end
      end

      WR_BURST: begin
        // A stalled beat keeps both the counter and the address unchanged.
        if (bmem_ready) begin
          cnt_next_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_next_s = RESP;
          end else begin
            state_next_s = WR_BURST;
          end
        end else begin
          state_next_s = WR_BURST;
        end
      end

      RESP: begin
        state_next_s = IDLE;
      end

      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    bmem_read_next_s  = 1'b0;
    bmem_write_next_s = 1'b0;
    bmem_wdata_next_s = '0;
    dfp_resp_next_s   = 1'b0;

    case (state_next_s)
      RD_REQ: begin
        bmem_read_next_s = 1'b1;
      end
      WR_BURST: begin
        bmem_write_next_s = 1'b1;
        bmem_wdata_next_s = line_next_s[beat_base(cnt_next_s) +: BEAT_WIDTH];
      end
      RESP: begin
        dfp_resp_next_s = 1'b1;
      end
      default: begin
        bmem_read_next_s = 1'b0;
      end
    endcase
  end

  assign dfp_rdata  = line_r;
  assign dfp_resp   = dfp_resp_r;
  assign bmem_addr  = addr_r;
  assign bmem_read  = bmem_read_r;
  assign bmem_write = bmem_write_r;
  assign bmem_wdata = bmem_wdata_r;

endmodule

// File: tb/tb_mp_cache_line_adapter.sv
// -----------------------------------------------------------------------------
// tb_mp_cache_line_adapter
// Directed bench for mp_cache_line_adapter. Inputs are driven 1 time unit
// after each rising edge; outputs (all registered) are sampled at the same
// point, i.e. they describe the cycle that just started.
// -----------------------------------------------------------------------------
module tb_mp_cache_line_adapter;
  import mp_cache_types::*;

  logic                  clk;
  logic                  rst_n;
  logic [ADDR_WIDTH-1:0] dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic                  dfp_resp;
  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [ADDR_WIDTH-1:0] bmem_raddr;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  int n_pass;
  int n_total;

  mp_cache_line_adapter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  localparam logic [63:0] A0 = 64'hA0A0_A0A0_A0A0_A0A0;
  localparam logic [63:0] A1 = 64'hA1A1_A1A1_A1A1_A1A1;
  localparam logic [63:0] A2 = 64'hA2A2_A2A2_A2A2_A2A2;
  localparam logic [63:0] A3 = 64'hA3A3_A3A3_A3A3_A3A3;
  localparam logic [63:0] D0 = 64'hD000_0000_0000_00D0;
  localparam logic [63:0] D1 = 64'hD111_1111_1111_11D1;
  localparam logic [63:0] D2 = 64'hD222_2222_2222_22D2;
  localparam logic [63:0] D3 = 64'hD333_3333_3333_33D3;
  localparam logic [63:0] E0 = 64'hE000_0000_0000_0000;
  localparam logic [63:0] E1 = 64'hE111_0000_0000_0000;
  localparam logic [63:0] E2 = 64'hE222_0000_0000_0000;
  localparam logic [63:0] E3 = 64'hE333_0000_0000_0000;
  localparam logic [63:0] B0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] B3 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] C0 = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] C1 = 64'hC1C1_C1C1_C1C1_C1C1;
  localparam logic [63:0] F0 = 64'hF0F0_0000_0000_0001;
  localparam logic [63:0] F1 = 64'hF1F1_0000_0000_0002;
  localparam logic [63:0] F2 = 64'hF2F2_0000_0000_0003;
  localparam logic [63:0] F3 = 64'hF3F3_0000_0000_0004;
  localparam logic [63:0] STRAY = 64'h0000_0000_0000_00FF;

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst_n       = 1'b0;
    dfp_addr    = 32'h0000_0000;
    dfp_read    = 1'b1;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    bmem_ready  = 1'b0;
    bmem_raddr  = 32'h0000_0000;
    bmem_rdata  = 64'h0;
    bmem_rvalid = 1'b0;

    // ---- Reset held 3 cycles with a pending read ----
    cyc();
    check("rst_bmem_read_c1", bmem_read, 1'b0);
    cyc();
    cyc();
    check("rst_dfp_resp", dfp_resp, 1'b0);
    check("rst_bmem_read", bmem_read, 1'b0);
    check("rst_bmem_write", bmem_write, 1'b0);
    check("rst_bmem_addr", bmem_addr, 32'h0);
    check("rst_bmem_wdata", bmem_wdata, 64'h0);
    check("rst_dfp_rdata", dfp_rdata, 256'h0);
    rst_n = 1'b1;
    cyc();
    check("rel_bmem_read", bmem_read, 1'b1);
    check("rel_bmem_addr", bmem_addr, 32'h0);
    cyc();
    check("rel_hold_no_ready", bmem_read, 1'b1);
    // Abandon this request while it waits for bmem_ready.
    rst_n    = 1'b0;
    dfp_read = 1'b0;
    cyc();
    check("rst_in_rdreq", bmem_read, 1'b0);
    rst_n = 1'b1;
    cyc();

    // ---- Fill with a gap between beats 1 and 2 ----
    dfp_addr   = 32'h1234_567F;
    dfp_read   = 1'b1;
    bmem_ready = 1'b1;
    cyc();
    check("fill_bmem_read", bmem_read, 1'b1);
    check("fill_bmem_addr", bmem_addr, 32'h1234_5660);
    cyc();
    check("fill_read_drop", bmem_read, 1'b0);
    bmem_rvalid = 1'b1; bmem_rdata = A0;
    cyc();
    bmem_rdata = A1;
    cyc();
    bmem_rvalid = 1'b0; bmem_rdata = 64'h0;
    cyc();
    check("fill_gap_no_resp", dfp_resp, 1'b0);
    bmem_rvalid = 1'b1; bmem_rdata = A2;
    cyc();
    bmem_rdata = A3;
    cyc();
    check("fill_resp", dfp_resp, 1'b1);
    check("fill_rdata", dfp_rdata, {A3, A2, A1, A0});
    bmem_rvalid = 1'b0;
    cyc();
    dfp_read = 1'b0;
    check("fill_resp_one_cycle", dfp_resp, 1'b0);
    check("fill_rdata_stable", dfp_rdata, {A3, A2, A1, A0});
    cyc();
    check("fill_no_retrigger", bmem_read, 1'b0);

    // ---- Writeback with one stall ----
    dfp_addr   = 32'h0000_0040;
    dfp_wdata  = {D3, D2, D1, D0};
    dfp_write  = 1'b1;
    bmem_ready = 1'b1;
    cyc();
    check("wb_c1_write", bmem_write, 1'b1);
    check("wb_c1_addr", bmem_addr, 32'h0000_0040);
    check("wb_c1_wdata", bmem_wdata, D0);
    cyc();
    check("wb_c2_wdata", bmem_wdata, D1);
    bmem_ready = 1'b0;
    cyc();
    check("wb_c3_stall_wdata", bmem_wdata, D1);
    check("wb_c3_stall_write", bmem_write, 1'b1);
    check("wb_c3_stall_addr", bmem_addr, 32'h0000_0040);
    bmem_ready = 1'b1;
    cyc();
    check("wb_c4_wdata", bmem_wdata, D2);
    check("wb_c4_no_resp", dfp_resp, 1'b0);
    cyc();
    check("wb_c5_wdata", bmem_wdata, D3);
    check("wb_c5_write", bmem_write, 1'b1);
    cyc();
    check("wb_resp", dfp_resp, 1'b1);
    check("wb_write_drop", bmem_write, 1'b0);
    cyc();
    dfp_write = 1'b0;
    check("wb_resp_one_cycle", dfp_resp, 1'b0);
    cyc();
    check("wb_no_retrigger", bmem_write, 1'b0);

    // ---- Read and write together: write wins ----
    dfp_addr  = 32'h0000_0100;
    dfp_wdata = {E3, E2, E1, E0};
    dfp_read  = 1'b1;
    dfp_write = 1'b1;
    cyc();
    check("both_write", bmem_write, 1'b1);
    check("both_no_read", bmem_read, 1'b0);
    check("both_wdata", bmem_wdata, E0);
    check("both_addr", bmem_addr, 32'h0000_0100);
    cyc();
    cyc();
    check("both_wdata_b2", bmem_wdata, E2);
    check("both_no_read_mid", bmem_read, 1'b0);
    cyc();
    cyc();
    check("both_resp", dfp_resp, 1'b1);
    cyc();
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    cyc();
    check("both_no_read_after", bmem_read, 1'b0);

    // ---- Stray beats in IDLE and RD_REQ, then a clean fill ----
    bmem_rvalid = 1'b1; bmem_rdata = STRAY;
    cyc();
    cyc();
    check("stray_idle_rdata", dfp_rdata, {E3, E2, E1, E0});
    check("stray_idle_resp", dfp_resp, 1'b0);
    dfp_addr = 32'h0000_0200;
    dfp_read = 1'b1;
    cyc();
    check("stray_fill_addr", bmem_addr, 32'h0000_0200);
    cyc();
    bmem_rdata = B0;
    cyc();
    bmem_rdata = B1;
    cyc();
    bmem_rdata = B2;
    cyc();
    bmem_rdata = B3;
    cyc();
    bmem_rvalid = 1'b0; bmem_rdata = 64'h0;
    check("stray_fill_resp", dfp_resp, 1'b1);
    check("stray_fill_rdata", dfp_rdata, {B3, B2, B1, B0});
    cyc();
    dfp_read = 1'b0;
    cyc();

    // ---- Reset after beat 1 of a fill, then a fresh fill at 0x80 ----
    dfp_addr = 32'h0000_0300;
    dfp_read = 1'b1;
    cyc();
    cyc();
    bmem_rvalid = 1'b1; bmem_rdata = C0;
    cyc();
    bmem_rdata = C1;
    cyc();
    rst_n       = 1'b0;
    dfp_read    = 1'b0;
    bmem_rvalid = 1'b0;
    cyc();
    check("abort_resp", dfp_resp, 1'b0);
    check("abort_rdata", dfp_rdata, 256'h0);
    check("abort_addr", bmem_addr, 32'h0);
    rst_n       = 1'b1;
    bmem_rvalid = 1'b1; bmem_rdata = STRAY;
    cyc();
    cyc();
    check("abort_late_beats_resp", dfp_resp, 1'b0);
    check("abort_late_beats_rdata", dfp_rdata, 256'h0);
    bmem_rvalid = 1'b0;
    dfp_addr    = 32'h0000_0080;
    dfp_read    = 1'b1;
    cyc();
    check("refill_read", bmem_read, 1'b1);
    check("refill_addr", bmem_addr, 32'h0000_0080);
    cyc();
    bmem_rvalid = 1'b1; bmem_rdata = F0;
    cyc();
    bmem_rdata = F1;
    cyc();
    bmem_rdata = F2;
    cyc();
    bmem_rdata = F3;
    cyc();
    bmem_rvalid = 1'b0;
    check("refill_resp", dfp_resp, 1'b1);
    check("refill_rdata", dfp_rdata, {F3, F2, F1, F0});
    cyc();
    dfp_read = 1'b0;
    check("refill_resp_one_cycle", dfp_resp, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
